// File: rtl/spi_pkg.sv
// Shared SPI frame constants and controller state encoding; also used by the
// peripheral-side decoder.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RW_BIT     = 15;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StGap
  } spi_state_e;

endpackage

// File: rtl/spi_controller_if.sv
// Request/response handshake plus SPI pins of the controller; master is the
// controller side, slave is the requester/peripheral harness side.
interface spi_controller_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              sclk;
  logic              ncs;
  logic              copi;
  logic              cipo;

  modport master (
    input  req_valid, req_write, req_addr, req_data, cipo,
    output req_ready, rsp_valid, rsp_data, busy, sclk, ncs, copi
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, cipo,
    input  req_ready, rsp_valid, rsp_data, busy, sclk, ncs, copi
  );

endinterface

// File: rtl/spi_clk_tick.sv
// Loadable down-counter: one-cycle tick every CLK_DIV enabled cycles, reloaded
// whenever disabled so each SETUP phase starts from a full count.
module spi_clk_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [7:0] DivLoad = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  assign o_tick = i_en && (r_cnt == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= DivLoad;
    end else if (!i_en || (r_cnt == 8'd0)) begin
      r_cnt <= DivLoad;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends 16-bit {R/W, addr, data} frames MSB first and
// returns the last eight CIPO bits of each frame.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.master io_bus
);

  localparam logic [3:0] GapLoad = 4'(CS_GAP - 1);
  localparam logic [3:0] LastBit = 4'(FRAME_BITS - 1);

  spi_state_e            r_state;
  logic [FRAME_BITS-1:0] r_tx;
  logic [DATA_W-1:0]     r_rx;
  logic [DATA_W-1:0]     r_rsp_data;
  logic [3:0]            r_bit_cnt;
  logic [3:0]            r_gap_cnt;
  logic                  r_sclk;
  logic                  r_ncs;
  logic                  r_copi;
  logic                  r_req_ready;
  logic                  r_busy;
  logic                  r_rsp_valid;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_tick_en;
  logic                  w_tick;

  // Read frames carry zero data bits on COPI.
  assign w_frame = {io_bus.req_write, io_bus.req_addr,
                    (io_bus.req_write ? io_bus.req_data : {DATA_W{1'b0}})};

  assign w_tick_en = (r_state == StSetup) || (r_state == StShift);

  spi_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_tick_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_sclk      <= 1'b0;
      r_ncs       <= 1'b1;
      r_copi      <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.req_valid && r_req_ready) begin
            r_tx        <= {w_frame[FRAME_BITS-2:0], 1'b0};
            r_copi      <= w_frame[RW_BIT];
            r_ncs       <= 1'b0;
            r_sclk      <= 1'b0;
            r_bit_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= StSetup;
          end
        end
        StSetup: begin
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          if (w_tick) begin
            if (r_sclk) begin
              // Falling edge: sample CIPO and present the next COPI bit together.
              r_sclk <= 1'b0;
              r_rx   <= {r_rx[DATA_W-2:0], io_bus.cipo};
              r_copi <= r_tx[FRAME_BITS-1];
              r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end else if (r_bit_cnt == LastBit) begin
              r_ncs       <= 1'b1;
              r_copi      <= 1'b0;
              r_rsp_data  <= r_rx;
              r_rsp_valid <= 1'b1;
              r_gap_cnt   <= GapLoad;
              r_state     <= StGap;
            end else begin
              r_sclk    <= 1'b1;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        StGap: begin
          if (r_gap_cnt == 4'd0) begin
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.req_ready = r_req_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.busy      = r_busy;
  assign io_bus.sclk      = r_sclk;
  assign io_bus.ncs       = r_ncs;
  assign io_bus.copi      = r_copi;

endmodule

// File: tb/tb_spi_controller.sv
// Bench: four controllers (CLK_DIV 1, 2, 4, 7) against a behavioural SPI register
// peripheral and a scoreboard register file.
module tb_spi_controller;

  localparam int unsigned NumDut = 4;
  localparam int unsigned CsGap  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req_valid_a [NumDut];
  logic       req_write_a [NumDut];
  logic [6:0] req_addr_a  [NumDut];
  logic [7:0] req_data_a  [NumDut];
  logic       req_ready_a [NumDut];
  logic       rsp_valid_a [NumDut];
  logic [7:0] rsp_data_a  [NumDut];
  logic       busy_a      [NumDut];
  logic       sclk_a      [NumDut];
  logic       ncs_a       [NumDut];
  logic       copi_a      [NumDut];
  bit         cipo_a      [NumDut];

  function automatic int unsigned div_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 7;
    endcase
  endfunction

  for (genvar g = 0; g < NumDut; g++) begin : gen_dut
    localparam int unsigned Div = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 7;
    spi_controller_if bus ();
    assign bus.req_valid  = req_valid_a[g];
    assign bus.req_write  = req_write_a[g];
    assign bus.req_addr   = req_addr_a[g];
    assign bus.req_data   = req_data_a[g];
    assign bus.cipo       = cipo_a[g];
    assign req_ready_a[g] = bus.req_ready;
    assign rsp_valid_a[g] = bus.rsp_valid;
    assign rsp_data_a[g]  = bus.rsp_data;
    assign busy_a[g]      = bus.busy;
    assign sclk_a[g]      = bus.sclk;
    assign ncs_a[g]       = bus.ncs;
    assign copi_a[g]      = bus.copi;
    spi_controller #(
      .CLK_DIV (Div),
      .CS_GAP  (CsGap)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Peripheral model and pin monitor, sampled on the falling system-clock edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]  pmem    [NumDut][128];
  logic [7:0]  ref_mem [NumDut][128];
  logic [15:0] shreg [NumDut];
  logic [15:0] frame_last [NumDut];
  logic [6:0]  paddr [NumDut];
  logic [7:0]  rsp_last [NumDut];
  bit p_ncs [NumDut], p_sclk [NumDut], p_busy [NumDut], p_ready [NumDut];
  int frames_done [NumDut], acc_cnt [NumDut], rsp_cnt [NumDut], rsp_misalign [NumDut];
  int idle_edges [NumDut], low_cnt [NumDut], low_len [NumDut], bitn [NumDut], nbits [NumDut];
  int t_rise [NumDut], pmin [NumDut], pmax [NumDut], f_pmin [NumDut], f_pmax [NumDut];
  int t_acc [NumDut], acc_gap [NumDut], busy_len [NumDut], t_ncs_rise [NumDut];
  int t_ready_rise [NumDut];

  always @(negedge clk) begin
    for (int g = 0; g < NumDut; g++) begin
      if (!rst_n) begin
        p_ncs[g] = 1'b1; p_sclk[g] = 1'b0; p_busy[g] = 1'b0; p_ready[g] = 1'b1;
        cipo_a[g] = 1'b0;
      end else begin
        if (rsp_valid_a[g]) begin
          rsp_cnt[g]++;
          rsp_last[g] = rsp_data_a[g];
          if (!(ncs_a[g] && !p_ncs[g])) rsp_misalign[g]++;
        end
        if (busy_a[g] && !p_busy[g]) begin
          acc_cnt[g]++;
          acc_gap[g] = cyc - t_acc[g];
          t_acc[g]   = cyc;
        end
        if (!busy_a[g] && p_busy[g]) busy_len[g] = cyc - t_acc[g];
        if (req_ready_a[g] && !p_ready[g]) t_ready_rise[g] = cyc;
        if (ncs_a[g]) begin
          if (sclk_a[g] != p_sclk[g]) idle_edges[g]++;
          if (!p_ncs[g]) begin
            t_ncs_rise[g] = cyc;
            frame_last[g] = shreg[g];
            low_len[g]    = low_cnt[g];
            nbits[g]      = bitn[g];
            f_pmin[g]     = pmin[g];
            f_pmax[g]     = pmax[g];
            if (bitn[g] == 16 && shreg[g][15]) pmem[g][shreg[g][14:8]] = shreg[g][7:0];
            cipo_a[g] = 1'b0;
            frames_done[g]++;
          end
        end else begin
          if (p_ncs[g]) begin
            low_cnt[g] = 0; bitn[g] = 0; shreg[g] = '0; pmin[g] = 100000; pmax[g] = 0;
          end
          low_cnt[g]++;
          if (sclk_a[g] && !p_sclk[g]) begin
            shreg[g] = {shreg[g][14:0], copi_a[g]};
            bitn[g]++;
            if (bitn[g] > 1) begin
              if (cyc - t_rise[g] < pmin[g]) pmin[g] = cyc - t_rise[g];
              if (cyc - t_rise[g] > pmax[g]) pmax[g] = cyc - t_rise[g];
            end
            t_rise[g] = cyc;
            if (bitn[g] == 8) paddr[g] = shreg[g][6:0];
          end
          // Once the address is known, shift out the addressed register MSB first.
          if (!sclk_a[g] && p_sclk[g] && bitn[g] >= 8 && bitn[g] < 16)
            cipo_a[g] = pmem[g][paddr[g]][15 - bitn[g]];
        end
        p_ncs[g]   = ncs_a[g];
        p_sclk[g]  = sclk_a[g];
        p_busy[g]  = busy_a[g];
        p_ready[g] = req_ready_a[g];
      end
    end
  end

  task automatic start_req(input int k, input bit w, input logic [6:0] a, input logic [7:0] d,
                           input bit drop);
    @(negedge clk);
    req_write_a[k] = w;
    req_addr_a[k]  = a;
    req_data_a[k]  = d;
    req_valid_a[k] = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (req_ready_a[k]) break;
      @(negedge clk);
    end
    check_eq("accept", {31'd0, req_ready_a[k]}, 32'd1);
    @(posedge clk);
    #1;
    if (drop) req_valid_a[k] = 1'b0;
  endtask

  task automatic wait_frame(input int k, input int target);
    int budget;
    budget = 40 * div_of(k) + 80;
    for (int t = 0; t < budget && frames_done[k] < target; t++) begin
      @(posedge clk);
      #2;
    end
    check_eq("frame_done", {31'd0, frames_done[k] >= target}, 32'd1);
  endtask

  task automatic check_frame(input int k, input bit w, input logic [6:0] a, input logic [7:0] d);
    int unsigned div;
    logic [15:0] exp_f;
    logic [7:0]  old;
    div   = div_of(k);
    old   = ref_mem[k][a];
    exp_f = (w ? 16'h8000 : 16'h0000) + 16'(a) * 16'd256 + (w ? 16'(d) : 16'h0000);
    repeat (CsGap + 2) @(posedge clk);
    #2;
    check_eq("copi_frame", frame_last[k], exp_f);
    check_eq("sclk_rises", nbits[k], 16);
    check_eq("rsp_data", rsp_last[k], old);
    check_eq("ncs_low", low_len[k], 33 * div);
    check_eq("sclk_period", (f_pmin[k] << 16) | f_pmax[k], ((2 * div) << 16) | (2 * div));
    check_eq("rsp_pulse", rsp_cnt[k], frames_done[k]);
    check_eq("rsp_align", rsp_misalign[k], 0);
    check_eq("ready_gap", t_ready_rise[k] - t_ncs_rise[k], CsGap);
    check_eq("busy_len", busy_len[k], 33 * div + CsGap);
    check_eq("periph_reg", pmem[k][a], w ? d : old);
    if (w) ref_mem[k][a] = d;
  endtask

  task automatic run_frame(input int k, input bit w, input logic [6:0] a, input logic [7:0] d);
    int fd0;
    fd0 = frames_done[k];
    start_req(k, w, a, d, 1'b1);
    wait_frame(k, fd0 + 1);
    check_frame(k, w, a, d);
  endtask

  initial begin
    int fd0, acc0, rsp0;
    for (int k = 0; k < NumDut; k++) begin
      req_valid_a[k] = 1'b0; req_write_a[k] = 1'b0; req_addr_a[k] = '0; req_data_a[k] = '0;
      for (int a = 0; a < 128; a++) begin
        pmem[k][a]    = 8'h00;
        ref_mem[k][a] = 8'h00;
      end
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NumDut; k++) begin
      check_eq("reset_pins", {26'd0, ncs_a[k], sclk_a[k], copi_a[k], req_ready_a[k], busy_a[k],
                              rsp_valid_a[k]}, 32'b100100);
      check_eq("reset_rsp_data", {24'd0, rsp_data_a[k]}, 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Abort a frame 40 cycles in; reset must act without waiting for a clock.
    rsp0 = rsp_cnt[2];
    fd0  = frames_done[2];
    start_req(2, 1'b1, 7'h10, 8'h3C, 1'b1);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset", {26'd0, ncs_a[2], sclk_a[2], copi_a[2], req_ready_a[2], busy_a[2],
                             rsp_valid_a[2]}, 32'b100100);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check_eq("abort_no_rsp", rsp_cnt[2] - rsp0, 0);
    check_eq("abort_no_frame", frames_done[2] - fd0, 0);

    run_frame(2, 1'b1, 7'h00, 8'hF0);

    pmem[2][4]    = 8'hA5;
    ref_mem[2][4] = 8'hA5;
    run_frame(2, 1'b0, 7'h04, 8'h5A);

    // Back-to-back at CLK_DIV=1 with req_valid held high across both frames.
    fd0  = frames_done[0];
    acc0 = acc_cnt[0];
    start_req(0, 1'b1, 7'h01, 8'h55, 1'b0);
    req_addr_a[0] = 7'h02;
    req_data_a[0] = 8'hAA;
    wait_frame(0, fd0 + 1);
    check_frame(0, 1'b1, 7'h01, 8'h55);
    check_eq("b2b_accepts", acc_cnt[0] - acc0, 2);
    req_valid_a[0] = 1'b0;
    check_eq("b2b_spacing", acc_gap[0], 1 + 33 + CsGap);
    wait_frame(0, fd0 + 2);
    check_frame(0, 1'b1, 7'h02, 8'hAA);

    // Requests arriving mid-frame must not disturb the frame in flight.
    fd0  = frames_done[2];
    acc0 = acc_cnt[2];
    start_req(2, 1'b1, 7'h11, 8'h22, 1'b1);
    repeat (20) @(posedge clk);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      req_valid_a[2] = ((t % 2) == 0);
      req_write_a[2] = 1'b0;
      req_addr_a[2]  = 7'h33;
      req_data_a[2]  = 8'h44;
    end
    @(negedge clk);
    req_valid_a[2] = 1'b0;
    wait_frame(2, fd0 + 1);
    check_frame(2, 1'b1, 7'h11, 8'h22);
    check_eq("ignored_req", acc_cnt[2] - acc0, 1);

    for (int i = 0; i < 200; i++) begin
      run_frame(i % NumDut, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)));
    end

    for (int k = 0; k < NumDut; k++) check_eq("sclk_while_ncs_high", idle_edges[k], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
